mmio_uart_tx: RTL and testbench

//   Memory-mapped UART transmitter on the CPU data-memory/IO bus. It sits beside the data memory and LED/switch port.
//   The CPU issues stores and loads (address, data_write, mem_wr) and this block is the responder.
//   A store to DATA queues one byte in a FIFO. The block then serialises each byte as an 8N1 frame on tx, LSB first.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/mmio_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the MMIO UART transmitter: register
//               offsets, FSM state encoding and STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [4:0] OFF_DATA   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h08;
    localparam logic [4:0] OFF_DIV    = 5'h10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with a register-array head; simultaneous
//               push and pop are both honoured when not empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter with a byte FIFO, a
//               programmable bit divider and combinational register reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [12:0] BASE_ADDR  = 13'h1000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] address,
    input  logic [63:0] data_write,
    input  logic        mem_wr,
    output logic [63:0] data_read,
    output logic        hit,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [4:0]    w_offset;
    logic          w_wr_data;
    logic          w_wr_status;
    logic          w_wr_div;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic [4:0]    w_cnt_ext;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_busy;
    logic          w_baud_zero;
    logic [15:0]   w_div_m1;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_ovf;
    logic [15:0]   r_div;
    logic [15:0]   r_baud;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_unused_ok;

    assign w_offset    = address[4:0];
    assign hit         = (address[12:5] == BASE_ADDR[12:5]);
    assign w_wr_data   = hit && mem_wr && (w_offset == OFF_DATA);
    assign w_wr_status = hit && mem_wr && (w_offset == OFF_STATUS);
    assign w_wr_div    = hit && mem_wr && (w_offset == OFF_DIV);
    assign w_unused_ok = &{1'b0, data_write[63:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_data),
        .pop   (w_pop),
        .din   (data_write[7:0]),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_wr_data && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_wr_status && data_write[3]) begin
            r_ovf <= 1'b0;
        end
    end

    // A divider of zero would stall the baud counter, so it is clamped to one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DIV_RESET;
        end else if (w_wr_div) begin
            r_div <= (data_write[15:0] == 16'd0) ? 16'd1 : data_write[15:0];
        end
    end

    assign w_div_m1    = r_div - 16'd1;
    assign w_baud_zero = (r_baud == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_nxt = ST_START;
            ST_START: if (w_baud_zero) w_state_nxt = ST_DATA;
            ST_DATA:  if (w_baud_zero && (r_bitcnt == 3'd7)) w_state_nxt = ST_STOP;
            ST_STOP:  if (w_baud_zero) w_state_nxt = w_empty ? ST_IDLE : ST_START;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop  = !w_empty && ((r_state == ST_IDLE) ||
                              ((r_state == ST_STOP) && w_baud_zero));
        w_busy = (r_state != ST_IDLE);
    end

    // Bit timing: every bit (including start/stop) holds for div cycles, and the
    // divider is re-sampled only when a new bit begins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx     <= 1'b1;
            r_shift  <= 8'd0;
            r_baud   <= 16'd0;
            r_bitcnt <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_baud  <= w_div_m1;
                    end
                end
                ST_START: begin
                    if (w_baud_zero) begin
                        r_tx     <= r_shift[0];
                        r_baud   <= w_div_m1;
                        r_bitcnt <= 3'd0;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_zero) begin
                        if (r_bitcnt == 3'd7) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                        r_baud <= w_div_m1;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_zero) begin
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_baud  <= w_div_m1;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign tx        = r_tx;
    assign w_cnt_ext = 5'(w_count);

    always_comb begin
        data_read = 64'h0;
        if (hit) begin
            case (w_offset)
                OFF_STATUS: begin
                    data_read[STAT_BUSY]  = w_busy;
                    data_read[STAT_FULL]  = w_full;
                    data_read[STAT_EMPTY] = w_empty;
                    data_read[STAT_OVF]   = r_ovf;
                    data_read[STAT_CNT_LSB +: 4] = w_cnt_ext[3:0];
                end
                OFF_DIV:  data_read[15:0] = r_div;
                default:  data_read = 64'h0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Directed self-checking bench for mmio_uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_uart_tx;

    localparam logic [12:0] A_DATA   = 13'h1000;
    localparam logic [12:0] A_STATUS = 13'h1008;
    localparam logic [12:0] A_DIV    = 13'h1010;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] address;
    logic [63:0] data_write;
    logic        mem_wr;
    logic [63:0] data_read;
    logic        hit;
    logic        tx;

    int n_vec = 0;
    int n_bad = 0;

    mmio_uart_tx #(
        .BASE_ADDR  (13'h1000),
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd434)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data_write (data_write),
        .mem_wr     (mem_wr),
        .data_read  (data_read),
        .hit        (hit),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [12:0] a, input logic [63:0] d);
        @(negedge clk);
        address    = a;
        data_write = d;
        mem_wr     = 1'b1;
        @(negedge clk);
        mem_wr     = 1'b0;
        data_write = 64'h0;
    endtask

    task automatic bus_read(input logic [12:0] a, output logic [63:0] d);
        address = a;
        mem_wr  = 1'b0;
        #1;
        d = data_read;
    endtask

    task automatic test_reset();
        logic [63:0] rd;
        bus_read(A_STATUS, rd);
        n_vec++;
        if (rd !== 64'h4) begin
            n_bad++;
            $display("FAIL reset_status got=%h want=%h", rd, 64'h4);
        end
        bus_read(A_DIV, rd);
        n_vec++;
        if (rd !== 64'd434) begin
            n_bad++;
            $display("FAIL reset_div got=%0d want=434", rd);
        end
        n_vec++;
        if (hit !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hit got=%b want=1", hit);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_vec++;
            if (tx !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_tx_idle cycle=%0d got=%b want=1", i, tx);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [63:0] rd;
        logic [7:0]  byt;
        logic        exp_tx;
        byt = 8'hA5;
        bus_write(A_DIV, 64'd4);
        bus_read(A_DIV, rd);
        n_vec++;
        if (rd !== 64'd4) begin
            n_bad++;
            $display("FAIL frame_div got=%0d want=4", rd);
        end
        bus_write(A_DATA, 64'hA5);
        bus_read(A_STATUS, rd);
        n_vec++;
        if (rd !== 64'h10) begin
            n_bad++;
            $display("FAIL frame_push_status got=%h want=%h", rd, 64'h10);
        end
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            #1;
            if (i < 4)       exp_tx = 1'b0;
            else if (i < 36) exp_tx = byt[(i - 4) / 4];
            else             exp_tx = 1'b1;
            n_vec++;
            if (tx !== exp_tx) begin
                n_bad++;
                $display("FAIL frame_tx cycle=%0d got=%b want=%b", i, tx, exp_tx);
            end
            n_vec++;
            if (data_read[0] !== (i < 40)) begin
                n_bad++;
                $display("FAIL frame_busy cycle=%0d got=%b want=%b", i, data_read[0], (i < 40));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic       exp_tx;
        logic [3:0] exp_cnt;
        int         ii, f, b;
        bytes[0] = 8'h01;
        bytes[1] = 8'hFE;
        bytes[2] = 8'h3C;
        bus_write(A_DIV, 64'd2);
        for (int t = 0; t < 66; t++) begin
            @(negedge clk);
            if (t < 3) begin
                address    = A_DATA;
                data_write = {56'h0, bytes[t]};
                mem_wr     = 1'b1;
            end else begin
                address    = A_STATUS;
                data_write = 64'h0;
                mem_wr     = 1'b0;
            end
            #1;
            if (t >= 2) begin
                ii = t - 2;
                f  = ii / 20;
                b  = (ii % 20) / 2;
                if (ii >= 60)    exp_tx = 1'b1;
                else if (b == 0) exp_tx = 1'b0;
                else if (b <= 8) exp_tx = bytes[f][b - 1];
                else             exp_tx = 1'b1;
                n_vec++;
                if (tx !== exp_tx) begin
                    n_bad++;
                    $display("FAIL b2b_tx sample=%0d got=%b want=%b", ii, tx, exp_tx);
                end
            end
            if (t == 3 || t == 21 || t == 22 || t == 41 || t == 42) begin
                exp_cnt = (t < 22) ? 4'd2 : (t < 42) ? 4'd1 : 4'd0;
                n_vec++;
                if (data_read[7:4] !== exp_cnt) begin
                    n_bad++;
                    $display("FAIL b2b_count t=%0d got=%0d want=%0d", t, data_read[7:4], exp_cnt);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] rd;
        bus_write(A_DIV, 64'd100);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            address    = A_DATA;
            data_write = 64'h0;
            mem_wr     = 1'b1;
        end
        @(negedge clk);
        bus_read(A_STATUS, rd);
        n_vec++;
        if (rd !== 64'h8B) begin
            n_bad++;
            $display("FAIL ovf_status got=%h want=%h", rd, 64'h8B);
        end
        bus_write(A_STATUS, 64'h7);
        bus_read(A_STATUS, rd);
        n_vec++;
        if (rd !== 64'h8B) begin
            n_bad++;
            $display("FAIL ovf_keep got=%h want=%h", rd, 64'h8B);
        end
        bus_write(A_STATUS, 64'h8);
        bus_read(A_STATUS, rd);
        n_vec++;
        if (rd !== 64'h83) begin
            n_bad++;
            $display("FAIL ovf_clear got=%h want=%h", rd, 64'h83);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] rd;
        repeat (150) @(negedge clk);
        n_vec++;
        if (tx !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_pre_tx got=%b want=0", tx);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_tx got=%b want=1", tx);
        end
        bus_read(A_STATUS, rd);
        n_vec++;
        if (rd !== 64'h4) begin
            n_bad++;
            $display("FAIL midrst_status got=%h want=%h", rd, 64'h4);
        end
        bus_read(A_DIV, rd);
        n_vec++;
        if (rd !== 64'd434) begin
            n_bad++;
            $display("FAIL midrst_div got=%0d want=434", rd);
        end
        rst = 1'b0;
        address = A_STATUS;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (tx !== 1'b1 || data_read[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_quiet cycle=%0d tx=%b busy=%b want tx=1 busy=0", i, tx, data_read[0]);
            end
        end
    endtask

    task automatic test_div_zero_and_decode();
        logic [63:0] rd;
        logic [7:0]  byt;
        logic        exp_tx;
        byt = 8'h96;
        bus_write(A_DIV, 64'd0);
        bus_read(A_DIV, rd);
        n_vec++;
        if (rd !== 64'd1) begin
            n_bad++;
            $display("FAIL div0_read got=%0d want=1", rd);
        end
        bus_write(A_DATA, 64'h96);
        address = A_STATUS;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (i == 0)      exp_tx = 1'b0;
            else if (i <= 8) exp_tx = byt[i - 1];
            else             exp_tx = 1'b1;
            n_vec++;
            if (tx !== exp_tx) begin
                n_bad++;
                $display("FAIL div0_tx cycle=%0d got=%b want=%b", i, tx, exp_tx);
            end
            n_vec++;
            if (data_read[0] !== (i < 10)) begin
                n_bad++;
                $display("FAIL div0_busy cycle=%0d got=%b want=%b", i, data_read[0], (i < 10));
            end
        end
        bus_read(13'h1018, rd);
        n_vec++;
        if (rd !== 64'h0 || hit !== 1'b1) begin
            n_bad++;
            $display("FAIL unmapped_read got=%h hit=%b want=0 hit=1", rd, hit);
        end
        bus_read(13'h1028, rd);
        n_vec++;
        if (rd !== 64'h0 || hit !== 1'b0) begin
            n_bad++;
            $display("FAIL outside_read got=%h hit=%b want=0 hit=0", rd, hit);
        end
        bus_read(13'h1020, rd);
        n_vec++;
        if (hit !== 1'b0) begin
            n_bad++;
            $display("FAIL outside_hit got=%b want=0", hit);
        end
        bus_write(13'h1020, 64'h55);
        bus_read(A_STATUS, rd);
        n_vec++;
        if (rd !== 64'h4) begin
            n_bad++;
            $display("FAIL outside_nopush got=%h want=%h", rd, 64'h4);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (tx !== 1'b1) begin
                n_bad++;
                $display("FAIL outside_tx cycle=%0d got=%b want=1", i, tx);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        address    = 13'h0;
        data_write = 64'h0;
        mem_wr     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_div_zero_and_decode();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
